// File: rtl/counter_pwm_gen.sv
// PWM generator driven by an external free-running up-counter.
// Duty is double-buffered and applied only at count 0; the count sequence is also checked.
//
// state | meaning
// IDLE  | disabled, output held low
// SYNC  | enabled, waiting for count 0 to align to a period boundary
// RUN   | generating PWM and checking that the count increments by one
module counter_pwm_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] counter_in,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    input  logic             err_clr,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             seq_error
);

    localparam logic [WIDTH:0]   DUTY_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH:0]   active_duty, shadow_duty, duty_sat, period_duty;
    logic [WIDTH-1:0] prev_count, count_exp;
    logic             pending, first_run;
    logic             accept, boundary, err_set;
    logic             pwm_next, tick_next, first_run_next;

    assign duty_ready = !pending;
    assign accept     = duty_valid && !pending;
    assign duty_sat   = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign count_exp  = prev_count + ONE;
    // At a boundary the compare must already see the duty being loaded this edge.
    assign period_duty = (boundary && pending) ? shadow_duty : active_duty;

    always_comb begin
        state_next     = state;
        pwm_next       = 1'b0;
        tick_next      = 1'b0;
        boundary       = 1'b0;
        err_set        = 1'b0;
        first_run_next = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = SYNC;
                SYNC: begin
                    if (counter_in == '0) begin
                        state_next     = RUN;
                        boundary       = 1'b1;
                        first_run_next = 1'b1;
                    end
                end
                RUN: begin
                    if (!first_run && (counter_in != count_exp)) begin
                        err_set    = 1'b1;
                        state_next = SYNC;
                    end else begin
                        boundary  = (counter_in == '0);
                        tick_next = boundary;
                        pwm_next  = ({1'b0, counter_in} < period_duty);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_duty <= '0;
            shadow_duty <= '0;
            pending     <= 1'b0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            seq_error   <= 1'b0;
            prev_count  <= '0;
            first_run   <= 1'b0;
        end else begin
            pwm_out     <= pwm_next;
            period_tick <= tick_next;
            first_run   <= first_run_next;
            if (enable && (state == RUN)) begin
                prev_count <= counter_in;
            end
            if (err_set) begin
                seq_error <= 1'b1;
            end else if (err_clr) begin
                seq_error <= 1'b0;
            end
            // Accept needs pending low, so it can never collide with a load.
            if (boundary && pending) begin
                active_duty <= shadow_duty;
                pending     <= 1'b0;
            end
            if (accept) begin
                shadow_duty <= duty_sat;
                pending     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_pwm_gen.sv
// Bench for counter_pwm_gen: directed phases plus a randomized phase, each cycle
// compared against a behavioural model of the PWM/duty/sequence rules.
module tb_counter_pwm_gen;

    localparam int W = 4;
    localparam int P = 16;
    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_RUN  = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] counter_in = '0;
    logic [W:0]   duty_in = '0;
    logic         duty_valid = 1'b0;
    logic         err_clr = 1'b0;
    logic         duty_ready, pwm_out, period_tick, seq_error;

    int checks = 0;
    int errors = 0;

    int cnt = 0;
    bit en = 1'b0;
    bit skip_next = 1'b0;

    int m_mode, m_active, m_shadow, m_prev;
    bit m_pending, m_pwm, m_tick, m_err, m_first;

    always #5 clock = ~clock;

    counter_pwm_gen #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .counter_in (counter_in),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .err_clr    (err_clr),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .seq_error  (seq_error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_active = 0; m_shadow = 0; m_prev = 0;
        m_pending = 0; m_pwm = 0; m_tick = 0; m_err = 0; m_first = 0;
    endtask

    // Expected behaviour for one clock, given the inputs presented before the edge.
    task automatic model_step(input bit e, input int c, input bit dv, input int din, input bit ec);
        bit accept, boundary, err_set, n_first, n_pwm, n_tick;
        int n_mode, duty;
        accept = dv && !m_pending;
        boundary = 0; err_set = 0; n_first = 0; n_pwm = 0; n_tick = 0;
        n_mode = m_mode;
        if (!e) begin
            n_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            n_mode = M_SYNC;
        end else if (m_mode == M_SYNC) begin
            if (c == 0) begin
                n_mode = M_RUN; boundary = 1; n_first = 1;
            end
        end else begin
            if (!m_first && c != (m_prev + 1) % P) begin
                err_set = 1; n_mode = M_SYNC;
            end else begin
                boundary = (c == 0);
                n_tick = boundary;
                duty = (boundary && m_pending) ? m_shadow : m_active;
                n_pwm = (c < duty);
            end
            m_prev = c;
        end
        if (boundary && m_pending) begin
            m_active = m_shadow; m_pending = 0;
        end
        if (accept) begin
            m_shadow = (din > P) ? P : din; m_pending = 1;
        end
        if (err_set) m_err = 1;
        else if (ec) m_err = 0;
        m_mode = n_mode; m_pwm = n_pwm; m_tick = n_tick; m_first = n_first;
    endtask

    task automatic cycle(input bit dv = 0, input int din = 0, input bit ec = 0);
        counter_in = cnt[W-1:0];
        enable = en;
        duty_valid = dv;
        duty_in = din[W:0];
        err_clr = ec;
        @(posedge clock);
        #1;
        model_step(en, cnt, dv, din, ec);
        chk("pwm_out", pwm_out, m_pwm);
        chk("period_tick", period_tick, m_tick);
        chk("seq_error", seq_error, m_err);
        chk("duty_ready", duty_ready, !m_pending);
        if (en) begin
            cnt = (cnt + 1 + (skip_next ? 1 : 0)) % P;
            skip_next = 0;
        end
        duty_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    // Align to the next tick, then count highs and ticks over one full period.
    task automatic measure_period(input string tag, input int exp_high,
                                  input int write_at = -1, input int wdata = 0);
        int highs, ticks, waited;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (!period_tick && waited < 40);
        chk({tag, "_tick_seen"}, period_tick, 1);
        highs = pwm_out;
        ticks = 1;
        for (int k = 1; k < P; k++) begin
            if (k == write_at) begin
                cycle(1, wdata);
                chk({tag, "_ready_low"}, duty_ready, 0);
            end else begin
                cycle();
            end
            highs += pwm_out;
            ticks += period_tick;
        end
        chk({tag, "_highs"}, highs, exp_high);
        chk({tag, "_ticks"}, ticks, 1);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_err", seq_error, 0);
        chk("rst_ready", duty_ready, 1);
        @(negedge clock);
        reset = 1'b0;

        en = 0;
        repeat (3) cycle();
        en = 1;
        cycle();
        cycle(1, 6);
        measure_period("d6a", 6);
        measure_period("d6b", 6);

        measure_period("d6_w12", 6, 7, 12);
        measure_period("d12", 12);

        cycle(1, 0);
        measure_period("d0", 0);
        cycle(1, 16);
        measure_period("d16", 16);
        cycle(1, 20);
        measure_period("d20", 16);

        cycle(1, 12);
        measure_period("d12b", 12);
        for (int i = 0; i < 40 && cnt != 9; i++) cycle();
        en = 0;
        cycle();
        chk("en_drop_pwm", pwm_out, 0);
        chk("en_drop_tick", period_tick, 0);
        repeat (3) begin
            cycle();
            chk("idle_tick", period_tick, 0);
        end
        en = 1;
        measure_period("resume12", 12);

        cycle(1, 6);
        measure_period("pre_skip", 6);
        for (int i = 0; i < 40 && cnt != 3; i++) cycle();
        skip_next = 1;
        cycle();
        cycle(0, 0, 1);
        chk("skip_err", seq_error, 1);
        chk("skip_pwm", pwm_out, 0);
        measure_period("post_skip", 6);
        cycle(0, 0, 1);
        chk("err_clr", seq_error, 0);

        for (int i = 0; i < 400; i++) begin
            bit dv, ec;
            if (en && $urandom_range(0, 49) == 0) en = 0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1;
            if ($urandom_range(0, 39) == 0) skip_next = 1;
            dv = ($urandom_range(0, 3) == 0);
            ec = ($urandom_range(0, 19) == 0);
            cycle(dv, int'($urandom_range(0, 31)), ec);
        end

        en = 1;
        cycle(0, 0, 1);
        for (int i = 0; i < 40 && !duty_ready; i++) cycle();
        cycle(1, 16);
        measure_period("pre_rst16", 16);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_ready", duty_ready, 1);
        chk("async_rst_err", seq_error, 0);
        chk("async_rst_tick", period_tick, 0);
        #2;
        reset = 1'b0;
        en = 0;
        repeat (4) cycle();
        en = 1;
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_pwm_gen.md
Name: counter_pwm_gen

Overview:
Downstream consumer of the 4-bit free-running up-counter's count output. It compares the incoming count against a programmable duty value to produce a registered PWM waveform. Duty updates are double-buffered and take effect only at period boundaries. The block also checks that the count sequence is consistent and flags any skipped or repeated value.

Parameters:
WIDTH, 4, width of the incoming count; period is 2**WIDTH clocks.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  same enable that drives the upstream counter; low forces IDLE
counter_in  input  WIDTH  current count from upstream counter
duty_in  input  WIDTH+1  requested high-time in clocks, 0..2**WIDTH
duty_valid  input  1  duty_in is valid this cycle
duty_ready  output  1  shadow register can accept a new duty
err_clr  input  1  clears sticky seq_error
pwm_out  output  1  registered PWM output
period_tick  output  1  one-cycle pulse at each period boundary in RUN
seq_error  output  1  sticky count-sequence error flag

Behaviour:
- Reset (async, immediate) forces the following values:
  - state=IDLE, active_duty=0, shadow_duty=0, pending=0
  - pwm_out=0, period_tick=0, seq_error=0, prev_count=0
  - duty_ready=1
- duty_ready = !pending, combinational from the pending flag.
- Duty accept: when duty_valid && duty_ready, shadow_duty <= min(duty_in, 2**WIDTH) and pending <= 1. duty_valid while not ready is ignored, with no stall or error.
- States:
  - IDLE:
    - pwm_out=0, period_tick=0.
    - enable=1 -> SYNC.
  - SYNC:
    - pwm_out=0.
    - Waits for counter_in==0.
    - On counter_in==0 -> RUN; in the same cycle perform a boundary load.
  - RUN:
    - Each cycle, pwm_out <= (counter_in < active_duty), giving a 1-clock latency from count to output.
    - prev_count <= counter_in.
- Boundary load: if pending=1, then active_duty <= shadow_duty and pending <= 0. Otherwise active_duty is unchanged.
- In RUN, when counter_in==0:
  - boundary load;
  - period_tick <= 1 for exactly one cycle;
  - pwm_out for this cycle uses the newly loaded duty.
- Simultaneous accept and boundary: the boundary sees the pre-edge pending. If pending=0, the newly accepted value stays pending until the next boundary. A duty is never lost and never applied mid-period.
- Sequence check, RUN only:
  - If counter_in != (prev_count+1) mod 2**WIDTH, set seq_error <= 1, force pwm_out <= 0, and go to SYNC.
  - The check is skipped on the first RUN cycle, the one that entered from SYNC.
- err_clr=1 clears seq_error. If err_clr coincides with a new error, set wins.
- enable=0 in any state -> IDLE next edge; pwm_out <= 0, period_tick <= 0.
  - active_duty and pending/shadow_duty are preserved.
- Duty arithmetic:
  - duty 0 -> pwm_out constant 0.
  - duty 2**WIDTH -> pwm_out constant 1 while in RUN.
  - duty in (2**WIDTH, 2**(WIDTH+1)) saturates to 2**WIDTH.
- Wrap: count 2**WIDTH-1 -> 0 is a legal increment and marks the boundary.

Test Plan:
- Reset asserted mid-RUN with pwm_out=1 -> pwm_out=0, duty_ready=1, seq_error=0 immediately, without waiting for a clock edge; after release, stays in IDLE until enable=1.
- duty_in=6 accepted during SYNC, counter runs 0..15 repeatedly:
  - pwm_out high for counts 0..5 (6 clocks), one cycle late, then low 10 clocks;
  - period_tick pulses once per 16 clocks.
- In RUN with active duty=6, write duty_in=12 at count 7:
  - duty_ready drops to 0 until the next count 0;
  - the current period stays 6 high;
  - the next period is 12 high.
- duty_in=0 -> pwm_out never high; duty_in=16 -> high every RUN cycle; duty_in=20 -> same as 16.
- Inject a skip (count 3 then 5):
  - seq_error=1, pwm_out=0, state returns to SYNC and re-enters RUN at the next count 0;
  - err_clr pulse clears seq_error.
- Drop enable at count 9 -> pwm_out=0 next edge and period_tick stays 0; re-raise enable -> resumes with the preserved duty at the next count 0.
